mdu_issue_ctrl: RTL

MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

---
 rtl/mdu_issue_if.sv | 25 ++
 rtl/mdu_issue_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/mdu_issue_if.sv
// Handshake and issue bundle between the E stage, the issue controller and the MDU.
interface mdu_issue_if;
    logic        req_valid;
    logic [3:0]  req_type;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        flush;
    logic        req_ready;
    logic        stall;
    logic [3:0]  MDU_type;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [3:0]  busy_cnt;

    modport master (
        output req_valid, req_type, req_rs, req_rt, flush,
        input  req_ready, stall, MDU_type, rs_data, rt_data, busy, busy_cnt
    );

    modport slave (
        input  req_valid, req_type, req_rs, req_rt, flush,
        output req_ready, stall, MDU_type, rs_data, rt_data, busy, busy_cnt
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// MDU issue controller: registers one MDU op per acceptance and blocks new issues
// until a started mult/div has had its full latency.
module mdu_issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_issue_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

    localparam logic [3:0] MultLat = 4'(MULT_LAT);
    localparam logic [3:0] DivLat  = 4'(DIV_LAT);

    state_e      r_state;
    logic [3:0]  r_mdu_type;
    logic [3:0]  r_busy_cnt;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic        r_busy;

    logic w_type_ok;
    logic w_req_start;
    logic w_iss_start;
    logic w_iss_move;
    logic w_ready;
    logic w_accept;

    assign w_type_ok   = (bus.req_type >= 4'd1) && (bus.req_type <= 4'd8);
    assign w_req_start = (bus.req_type >= 4'd1) && (bus.req_type <= 4'd4);
    assign w_iss_start = (r_mdu_type >= 4'd1) && (r_mdu_type <= 4'd4);
    assign w_iss_move  = (r_mdu_type >= 4'd5) && (r_mdu_type <= 4'd8);

    always_comb begin
        w_ready = 1'b0;
        if (reset) begin
            case (r_state)
                StIdle:  w_ready = 1'b1;
                StIssue: w_ready = w_iss_move;
                StBusy:  w_ready = (r_busy_cnt == 4'd1);
                default: w_ready = 1'b0;
            endcase
        end
    end

    assign w_accept = bus.req_valid && w_ready && !bus.flush && w_type_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_mdu_type <= 4'd0;
            r_busy_cnt <= 4'd0;
            r_rs       <= 32'd0;
            r_rt       <= 32'd0;
            r_busy     <= 1'b0;
        end else begin
            r_mdu_type <= w_accept ? bus.req_type : 4'd0;
            if (w_accept) begin
                r_rs <= bus.req_rs;
                r_rt <= bus.req_rt;
            end

            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state <= StIssue;
                        r_busy  <= w_req_start;
                    end
                end
                StIssue: begin
                    if (w_iss_start) begin
                        // codes 1,2 are mult/multu, 3,4 are div/divu
                        r_state    <= StBusy;
                        r_busy_cnt <= (r_mdu_type <= 4'd2) ? MultLat : DivLat;
                        r_busy     <= 1'b1;
                    end else if (w_accept) begin
                        r_state <= StIssue;
                        r_busy  <= w_req_start;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                StBusy: begin
                    if (r_busy_cnt == 4'd1) begin
                        r_busy_cnt <= 4'd0;
                        if (w_accept) begin
                            r_state <= StIssue;
                            r_busy  <= w_req_start;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_busy_cnt <= r_busy_cnt - 4'd1;
                        r_busy     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    // Combinational on purpose: flush does not suppress the stall request.
    assign bus.stall     = bus.req_valid && w_type_ok && !w_ready;
    assign bus.MDU_type  = r_mdu_type;
    assign bus.rs_data   = r_rs;
    assign bus.rt_data   = r_rt;
    assign bus.busy      = r_busy;
    assign bus.busy_cnt  = r_busy_cnt;
endmodule
